// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker game datapath: grid geometry, the
// level-controller interface widths and the row engine state encoding.
package stacker_pkg;

   localparam int GRID_W_DEFAULT = 8;
   localparam int SPEED_WIDTH    = 11;
   localparam int NB_WIDTH       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/block_sweeper_frame_divider.sv
// Divides the video frame tick down to one step pulse every spd ticks;
// the step is combinational so the caller moves on the spd-th tick itself.
module frame_divider #(
   parameter int SPEED_W = 11
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               clear,
   input  logic               tick,
   input  logic [SPEED_W-1:0] spd,
   output logic               step
);

   logic [SPEED_W-1:0] count;
   logic               at_end;

   assign at_end = (count == (spd - SPEED_W'(1)));
   assign step   = tick & at_end & ~clear;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= at_end ? '0 : count + SPEED_W'(1);
      end
   end

endmodule

// File: rtl/block_sweeper.sv
// Row engine: sweeps a run of lit blocks across one grid row and, on drop,
// intersects it with the row below to report success or failure.
module block_sweeper
   import stacker_pkg::*;
#(
   parameter int GRID_W  = GRID_W_DEFAULT,
   parameter int SPEED_W = SPEED_WIDTH,
   parameter int NB_W    = NB_WIDTH
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               drop,
   input  logic [SPEED_W-1:0] speed_count,
   input  logic [NB_W-1:0]    num_blocks,
   output logic [GRID_W-1:0]  row_mask,
   output logic [3:0]         row_col,
   output logic               busy,
   output logic               next_signal,
   output logic               fail,
   output logic [GRID_W-1:0]  base_mask
);

   localparam int N_W = $clog2(GRID_W + 1);

   sweep_state_t       state, state_next;
   logic               load, do_drop, tick_en, step, advance;
   logic [SPEED_W-1:0] spd_q, spd_load;
   logic [N_W-1:0]     n_q, n_load;
   logic [31:0]        nb_ext, n_sel;
   logic [GRID_W-1:0]  mask_load, overlap, mask_move;
   logic [3:0]         col_move;
   logic               dir_left, dir_move;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start is honoured only outside SWEEP, so it beats a drop in DONE;
   // in SWEEP a drop beats a coincident frame tick.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      do_drop    = 1'b0;
      tick_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            if (drop) begin
               do_drop    = 1'b1;
               state_next = ST_DONE;
            end else begin
               tick_en = frame_tick;
            end
         end
         ST_DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ST_SWEEP;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   frame_divider #(.SPEED_W(SPEED_W)) u_divider (
      .clk    (clk),
      .resetn (resetn),
      .clear  (load),
      .tick   (tick_en),
      .spd    (spd_q),
      .step   (step)
   );

   always_comb begin
      spd_load = (speed_count == '0) ? SPEED_W'(1) : speed_count;
      nb_ext   = 32'(num_blocks);
      if (nb_ext == 32'd0) begin
         n_sel = 32'd1;
      end else if (nb_ext > 32'(GRID_W)) begin
         n_sel = 32'(GRID_W);
      end else begin
         n_sel = nb_ext;
      end
      n_load    = N_W'(n_sel);
      mask_load = '0;
      for (int i = 0; i < GRID_W; i++) begin
         mask_load[i] = (32'(i) < n_sel);
      end
   end

   // A move that would push a lit bit off either edge turns into a move
   // the other way, so the run bounces without ever pausing at the wall.
   always_comb begin
      mask_move = row_mask;
      col_move  = row_col;
      dir_move  = dir_left;
      if (!dir_left) begin
         if (row_mask[GRID_W-1]) begin
            dir_move  = 1'b1;
            mask_move = row_mask >> 1;
            col_move  = row_col - 4'd1;
         end else begin
            mask_move = row_mask << 1;
            col_move  = row_col + 4'd1;
         end
      end else begin
         if (row_mask[0]) begin
            dir_move  = 1'b0;
            mask_move = row_mask << 1;
            col_move  = row_col + 4'd1;
         end else begin
            mask_move = row_mask >> 1;
            col_move  = row_col - 4'd1;
         end
      end
   end

   assign advance = step && (n_q != N_W'(GRID_W));
   assign overlap = row_mask & base_mask;
   assign busy    = (state == ST_SWEEP);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_mask    <= '0;
         row_col     <= '0;
         dir_left    <= 1'b0;
         spd_q       <= SPEED_W'(1);
         n_q         <= N_W'(1);
         next_signal <= 1'b0;
         fail        <= 1'b0;
         base_mask   <= '1;
      end else if (load) begin
         row_mask    <= mask_load;
         row_col     <= '0;
         dir_left    <= 1'b0;
         spd_q       <= spd_load;
         n_q         <= n_load;
         next_signal <= 1'b0;
         fail        <= 1'b0;
      end else if (do_drop) begin
         if (overlap != '0) begin
            next_signal <= 1'b1;
            base_mask   <= overlap;
         end else begin
            fail        <= 1'b1;
            base_mask   <= '1;
         end
      end else if (advance) begin
         row_mask <= mask_move;
         row_col  <= col_move;
         dir_left <= dir_move;
      end
   end

endmodule
